// File: rtl/wb_write_arbiter.sv
// Register-file write-port arbiter.
// Merges the in-order pipeline write-back (always has priority) with a
// long-latency producer buffered in a small FIFO. Queued results drain in
// cycles where the pipeline does not write. A per-entry live bit lets a
// younger pipeline write to the same register kill an older queued write.
// The live bits also form a pending-write scoreboard that ID checks.
//
// Ports:
//   clk, rst                       clock, async active-low reset
//   pipe_we/pipe_waddr/pipe_wdata  pipeline write-back request
//   lu_valid/lu_ready              long-latency handshake (lu_ready comb)
//   lu_waddr/lu_wdata              long-latency payload
//   we/waddr/wdata                 registered regfile write port
//   chk_addr1/2, chk_hit1/2        ID scoreboard lookup (comb)
//   q_count, full_o                FIFO occupancy
module wb_write_arbiter #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned PTR_W = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             pipe_we,
   input  logic [4:0]       pipe_waddr,
   input  logic [31:0]      pipe_wdata,
   input  logic             lu_valid,
   output logic             lu_ready,
   input  logic [4:0]       lu_waddr,
   input  logic [31:0]      lu_wdata,
   output logic             we,
   output logic [4:0]       waddr,
   output logic [31:0]      wdata,
   input  logic [4:0]       chk_addr1,
   input  logic [4:0]       chk_addr2,
   output logic             chk_hit1,
   output logic             chk_hit2,
   output logic [PTR_W:0]   q_count,
   output logic             full_o
);

   localparam int unsigned CNT_W = PTR_W + 1;

   logic [4:0]       addr_q [DEPTH];
   logic [4:0]       addr_d [DEPTH];
   logic [31:0]      data_q [DEPTH];
   logic [31:0]      data_d [DEPTH];
   logic [DEPTH-1:0] live_q, live_d;
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             we_q, we_d;
   logic [4:0]       waddr_q, waddr_d;
   logic [31:0]      wdata_q, wdata_d;

   logic enq;
   logic pop;
   logic kill;

   assign lu_ready = rst && (count_q < CNT_W'(DEPTH));
   assign q_count  = count_q;
   assign full_o   = (count_q == CNT_W'(DEPTH));
   assign we       = we_q;
   assign waddr    = waddr_q;
   assign wdata    = wdata_q;

   // Next-state: WAW kill, output arbitration/pop, then enqueue.
   always_comb begin
      addr_d   = addr_q;
      data_d   = data_q;
      live_d   = live_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      we_d     = 1'b0;
      waddr_d  = waddr_q;
      wdata_d  = wdata_q;
      pop      = 1'b0;

      enq  = lu_valid && lu_ready && (lu_waddr != 5'd0);
      kill = pipe_we && (pipe_waddr != 5'd0);

      for (int unsigned i = 0; i < DEPTH; i++) begin
         if (kill && addr_q[i] == pipe_waddr) begin
            live_d[i] = 1'b0;
         end
      end

      if (pipe_we) begin
         we_d    = 1'b1;
         waddr_d = pipe_waddr;
         wdata_d = pipe_wdata;
      end else if (count_q != CNT_W'(0)) begin
         // Dead head is popped silently; waddr/wdata keep their last value.
         pop = 1'b1;
         if (live_q[rd_ptr_q]) begin
            we_d    = 1'b1;
            waddr_d = addr_q[rd_ptr_q];
            wdata_d = data_q[rd_ptr_q];
         end
         live_d[rd_ptr_q] = 1'b0;
      end

      // Tail slot is never the popped slot (accept requires not full).
      if (enq) begin
         addr_d[wr_ptr_q] = lu_waddr;
         data_d[wr_ptr_q] = lu_wdata;
         live_d[wr_ptr_q] = 1'b1;
         wr_ptr_d         = wr_ptr_q + PTR_W'(1);
      end

      if (pop) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end

      unique case ({enq, pop})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
   end

   // Scoreboard lookup over live queued entries.
   always_comb begin
      chk_hit1 = 1'b0;
      chk_hit2 = 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
         if (live_q[i] && addr_q[i] == chk_addr1) chk_hit1 = 1'b1;
         if (live_q[i] && addr_q[i] == chk_addr2) chk_hit2 = 1'b1;
      end
      if (chk_addr1 == 5'd0) chk_hit1 = 1'b0;
      if (chk_addr2 == 5'd0) chk_hit2 = 1'b0;
   end

   // State registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            addr_q[i] <= 5'd0;
            data_q[i] <= 32'd0;
         end
         live_q   <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         we_q     <= 1'b0;
         waddr_q  <= 5'd0;
         wdata_q  <= 32'd0;
      end else begin
         addr_q   <= addr_d;
         data_q   <= data_d;
         live_q   <= live_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         we_q     <= we_d;
         waddr_q  <= waddr_d;
         wdata_q  <= wdata_d;
      end
   end

endmodule

// File: tb/tb_wb_write_arbiter.sv
// Directed self-checking bench for wb_write_arbiter.
module tb_wb_write_arbiter;

   logic        clk;
   logic        rst;
   logic        pipe_we;
   logic [4:0]  pipe_waddr;
   logic [31:0] pipe_wdata;
   logic        lu_valid;
   logic        lu_ready;
   logic [4:0]  lu_waddr;
   logic [31:0] lu_wdata;
   logic        we;
   logic [4:0]  waddr;
   logic [31:0] wdata;
   logic [4:0]  chk_addr1;
   logic [4:0]  chk_addr2;
   logic        chk_hit1;
   logic        chk_hit2;
   logic [2:0]  q_count;
   logic        full_o;

   int errors = 0;
   int checks = 0;

   wb_write_arbiter #(.DEPTH(4), .PTR_W(2)) dut (
      .clk(clk), .rst(rst),
      .pipe_we(pipe_we), .pipe_waddr(pipe_waddr), .pipe_wdata(pipe_wdata),
      .lu_valid(lu_valid), .lu_ready(lu_ready),
      .lu_waddr(lu_waddr), .lu_wdata(lu_wdata),
      .we(we), .waddr(waddr), .wdata(wdata),
      .chk_addr1(chk_addr1), .chk_addr2(chk_addr2),
      .chk_hit1(chk_hit1), .chk_hit2(chk_hit2),
      .q_count(q_count), .full_o(full_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance one edge and settle past it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic lu_offer(input logic v, input logic [4:0] a, input logic [31:0] d);
      lu_valid = v;
      lu_waddr = a;
      lu_wdata = d;
   endtask

   task automatic pipe(input logic w, input logic [4:0] a, input logic [31:0] d);
      pipe_we    = w;
      pipe_waddr = a;
      pipe_wdata = d;
   endtask

   initial begin
      rst = 1'b0;
      pipe(1'b0, 5'd0, 32'd0);
      lu_offer(1'b0, 5'd0, 32'd0);
      chk_addr1 = 5'd3;
      chk_addr2 = 5'd0;
      #12;
      check("rst_lu_ready", 32'(lu_ready), 32'd0);
      check("rst_we", 32'(we), 32'd0);
      tick();
      rst = 1'b1;
      #1;
      check("idle_we", 32'(we), 32'd0);
      check("idle_waddr", 32'(waddr), 32'd0);
      check("idle_wdata", wdata, 32'd0);
      check("idle_lu_ready", 32'(lu_ready), 32'd1);
      check("idle_q_count", 32'(q_count), 32'd0);
      check("idle_hit1", 32'(chk_hit1), 32'd0);

      // Plain pipeline write, one-cycle latency.
      pipe(1'b1, 5'd5, 32'h1234);
      tick();
      check("pipe_we", 32'(we), 32'd1);
      check("pipe_waddr", 32'(waddr), 32'd5);
      check("pipe_wdata", wdata, 32'h1234);

      // Fill FIFO while pipeline holds the port.
      lu_offer(1'b1, 5'd3, 32'hA0); tick();
      lu_offer(1'b1, 5'd4, 32'hA1); tick();
      lu_offer(1'b1, 5'd6, 32'hA2); tick();
      lu_offer(1'b1, 5'd7, 32'hA3); tick();
      lu_offer(1'b0, 5'd0, 32'd0);
      chk_addr1 = 5'd6;
      chk_addr2 = 5'd4;
      #1;
      check("full_q_count", 32'(q_count), 32'd4);
      check("full_full_o", 32'(full_o), 32'd1);
      check("full_lu_ready", 32'(lu_ready), 32'd0);
      check("full_hit1_6", 32'(chk_hit1), 32'd1);
      check("full_hit2_4", 32'(chk_hit2), 32'd1);
      check("full_pipe_still_wins", 32'(waddr), 32'd5);

      // Drain in order.
      pipe(1'b0, 5'd0, 32'd0);
      tick();
      check("drain0_we", 32'(we), 32'd1);
      check("drain0_waddr", 32'(waddr), 32'd3);
      check("drain0_wdata", wdata, 32'hA0);
      check("drain0_q_count", 32'(q_count), 32'd3);
      tick();
      check("drain1_waddr", 32'(waddr), 32'd4);
      check("drain1_wdata", wdata, 32'hA1);
      check("drain1_hit2_4", 32'(chk_hit2), 32'd0);
      tick();
      check("drain2_waddr", 32'(waddr), 32'd6);
      check("drain2_wdata", wdata, 32'hA2);
      tick();
      check("drain3_we", 32'(we), 32'd1);
      check("drain3_waddr", 32'(waddr), 32'd7);
      check("drain3_wdata", wdata, 32'hA3);
      check("drain3_q_count", 32'(q_count), 32'd0);
      tick();
      check("empty_we", 32'(we), 32'd0);
      check("empty_hold_waddr", 32'(waddr), 32'd7);
      check("empty_hold_wdata", wdata, 32'hA3);

      // WAW kill: queue 9<-BB, then pipeline writes 9<-CC.
      chk_addr1 = 5'd9;
      lu_offer(1'b1, 5'd9, 32'hBB);
      pipe(1'b1, 5'd2, 32'h22);
      tick();
      lu_offer(1'b0, 5'd0, 32'd0);
      #1;
      check("waw_q_count", 32'(q_count), 32'd1);
      check("waw_hit_before", 32'(chk_hit1), 32'd1);
      pipe(1'b1, 5'd9, 32'hCC);
      tick();
      check("waw_we", 32'(we), 32'd1);
      check("waw_waddr", 32'(waddr), 32'd9);
      check("waw_wdata", wdata, 32'hCC);
      check("waw_hit_after", 32'(chk_hit1), 32'd0);
      check("waw_q_count_dead", 32'(q_count), 32'd1);
      pipe(1'b0, 5'd0, 32'd0);
      tick();
      check("waw_dead_pop_we", 32'(we), 32'd0);
      check("waw_dead_pop_q", 32'(q_count), 32'd0);
      check("waw_dead_pop_wdata", wdata, 32'hCC);

      // Address-0 offer completes without enqueue.
      lu_offer(1'b1, 5'd0, 32'hDEAD);
      #1;
      check("a0_lu_ready", 32'(lu_ready), 32'd1);
      tick();
      lu_offer(1'b0, 5'd0, 32'd0);
      check("a0_q_count", 32'(q_count), 32'd0);
      tick();
      check("a0_no_write", 32'(we), 32'd0);

      // Simultaneous accept and pop keeps count.
      pipe(1'b1, 5'd1, 32'h1);
      lu_offer(1'b1, 5'd10, 32'h11);
      tick();
      pipe(1'b0, 5'd0, 32'd0);
      lu_offer(1'b1, 5'd11, 32'h22);
      tick();
      lu_offer(1'b0, 5'd0, 32'd0);
      check("sim_q_count", 32'(q_count), 32'd1);
      check("sim_waddr", 32'(waddr), 32'd10);
      check("sim_wdata", wdata, 32'h11);
      tick();
      check("sim2_waddr", 32'(waddr), 32'd11);
      check("sim2_wdata", wdata, 32'h22);
      check("sim2_q_count", 32'(q_count), 32'd0);

      // Async reset with three queued entries.
      pipe(1'b1, 5'd1, 32'h55);
      lu_offer(1'b1, 5'd12, 32'hC0); tick();
      lu_offer(1'b1, 5'd13, 32'hC1); tick();
      lu_offer(1'b1, 5'd14, 32'hC2); tick();
      lu_offer(1'b0, 5'd0, 32'd0);
      check("pre_rst_q_count", 32'(q_count), 32'd3);
      check("pre_rst_we", 32'(we), 32'd1);
      #2;
      rst = 1'b0;
      #1;
      check("rst_async_q_count", 32'(q_count), 32'd0);
      check("rst_async_we", 32'(we), 32'd0);
      check("rst_async_lu_ready", 32'(lu_ready), 32'd0);
      pipe(1'b0, 5'd0, 32'd0);
      tick();
      rst = 1'b1;
      for (int k = 0; k < 4; k++) begin
         tick();
         check("post_rst_we", 32'(we), 32'd0);
         check("post_rst_q_count", 32'(q_count), 32'd0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/wb_write_arbiter.md
Name: wb_write_arbiter

Overview:
- Sole driver of the register-file write port (we/waddr/wdata).
- Merges two producers:
  - the in-order pipeline write-back (MEM/WB output, never stalled by this block);
  - a long-latency unit (load-miss / divider) with a valid/ready handshake, buffered in a small FIFO.
- The pipeline always wins the port. Queued long-latency results drain in idle slots.
- Provides a pending-write scoreboard to ID so it stalls on operands still queued here.

Parameters:
- DEPTH, 4, long-latency FIFO entries (power of two, ≥2)
- PTR_W, 2, log2(DEPTH)

Ports:
- clk  in  1  clock, all state on posedge
- rst  in  1  asynchronous reset, active-low (0 = reset)
- pipe_we  in  1  pipeline write request this cycle
- pipe_waddr  in  5  pipeline destination register
- pipe_wdata  in  32  pipeline result
- lu_valid  in  1  long-latency result offered
- lu_ready  out  1  FIFO can accept
- lu_waddr  in  5  long-latency destination
- lu_wdata  in  32  long-latency result
- we  out  1  regfile write enable (registered)
- waddr  out  5  regfile write address (registered)
- wdata  out  32  regfile write data (registered)
- chk_addr1  in  5  ID operand 1 address
- chk_addr2  in  5  ID operand 2 address
- chk_hit1  out  1  chk_addr1 has a live queued write
- chk_hit2  out  1  chk_addr2 has a live queued write
- q_count  out  PTR_W+1  occupied FIFO entries
- full_o  out  1  q_count == DEPTH

Behaviour:
- Reset (rst=0, async):
  - we=0, waddr=0, wdata=0.
  - FIFO empty: pointers 0, all live bits 0, q_count=0.
  - lu_ready=0 while rst=0.
- lu_ready = rst && (q_count < DEPTH), combinational.
- Accept = lu_valid && lu_ready.
  - lu_waddr != 0: enqueue {addr, data, live=1} at the tail.
  - lu_waddr == 0: handshake completes, nothing enqueued.
- Output register, updated every posedge (latency 1 cycle):
  - P1: pipe_we=1 → we=1, waddr=pipe_waddr, wdata=pipe_wdata. No pop.
  - P2: else if FIFO non-empty and head live → we=1, waddr/wdata from head. Pop.
  - P3: else if FIFO non-empty and head dead → we=0. Pop (discarded, one cycle).
  - P4: else → we=0. waddr/wdata hold their previous values.
- WAW kill: when pipe_we=1 and pipe_waddr != 0, every live FIFO entry whose addr == pipe_waddr is marked dead at that edge.
  - An entry accepted in the same cycle is younger than the pipeline write and is not killed.
  - If the head is popped in the same cycle, P1 applies, so there is no pop and no conflict.
- Simultaneous accept and pop: legal. q_count is unchanged, pointers both advance.
- Accept when full is impossible (lu_ready=0).
- Pointers wrap modulo DEPTH. q_count ranges 0..DEPTH.
- chk_hitN = (chk_addrN != 0) && any live entry with addr == chk_addrN. Combinational, FIFO contents only.
  - The value in the output register is not reported. The regfile's same-cycle write bypass covers it.
- pipe_we=1 with pipe_waddr=0 is forwarded unchanged. The regfile discards it.
- Starvation: the FIFO drains only in cycles with pipe_we=0. No fairness guarantee; the pipeline owns this.
- Reset asserted mid-drain: the FIFO is flushed, and queued results are lost by design.

Test Plan:
- Reset release, idle inputs → we=0, waddr=0, wdata=0, lu_ready=1, q_count=0, chk_hit1=0.
- pipe_we=1, pipe_waddr=5, pipe_wdata=32'h1234 in cycle N → at edge N+1: we=1, waddr=5, wdata=32'h1234.
- lu_valid with addrs 3,4,6,7 (data 0xA0..0xA3) while pipe_we=1 held high → q_count=4, full_o=1, lu_ready=0, chk_addr1=6 gives chk_hit1=1. Drop pipe_we → writes 3,4,6,7 appear on consecutive cycles with matching data, q_count returns to 0.
- Queue addr 9 (data 0xBB), then pipe write addr 9 (data 0xCC) while it is still queued → regfile sees 9←0xCC only. The dead entry drains with we=0, and chk_hit for 9 drops at the kill edge.
- lu_waddr=0 with lu_valid=1 → handshake accepted, q_count stays 0, no write issued.
- rst pulsed low with 3 entries queued → q_count=0 and we=0 immediately (async). No queued write appears after release.
